// File: rtl/fmult_arb_pkg.sv
// Shared constants and the result record type for the fmult round-robin arbiter.
package fmult_arb_pkg;

  localparam int NREQ_DEF  = 4;
  localparam int WIDTH_DEF = 16;
  localparam int FRAC_DEF  = 7;

  function automatic int id_w(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  localparam int ID_W_DEF = id_w(NREQ_DEF);

  // Result record at the default configuration; the top builds the same layout
  // from its own parameters.
  typedef struct packed {
    logic [WIDTH_DEF-1:0] result;
    logic                 ovr;
    logic [ID_W_DEF-1:0]  id;
  } fmult_res_t;

endpackage

// File: rtl/fmult.sv
// Signed fixed-point multiplier: full product, arithmetic shift by FRAC,
// low WIDTH bits returned; overflow when the shifted product does not fit.
module fmult #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 7
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_ovr,
  output logic [WIDTH-1:0] o_p,
  output logic             o_ovr
);

  logic signed [2*WIDTH-1:0] a_ext_w;
  logic signed [2*WIDTH-1:0] b_ext_w;
  logic signed [2*WIDTH-1:0] prod_w;
  logic signed [2*WIDTH-1:0] shr_w;

  assign a_ext_w = {{WIDTH{i_a[WIDTH-1]}}, i_a};
  assign b_ext_w = {{WIDTH{i_b[WIDTH-1]}}, i_b};
  assign prod_w  = a_ext_w * b_ext_w;
  assign shr_w   = prod_w >>> FRAC;

  assign o_p   = shr_w[WIDTH-1:0];
  // Fits only when every bit above the result MSB is a copy of it.
  assign o_ovr = i_ovr | (shr_w[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){shr_w[WIDTH-1]}});

endmodule

// File: rtl/fmult_rr_pick.sv
// Combinational round-robin pick: rotate requests by ptr, take the lowest set
// bit, rotate the winner back to an absolute index and one-hot grant.
module fmult_rr_pick
  import fmult_arb_pkg::*;
#(
  parameter int N   = NREQ_DEF,
  parameter int IDW = id_w(N)
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [N-1:0]   gnt_o,
  output logic [IDW-1:0] idx_o,
  output logic           any_o
);

  logic [N-1:0]   rot_w;
  logic [IDW-1:0] off_w;
  logic [IDW-1:0] src_w;

  function automatic int wrap(input int v);
    return (v >= N) ? v - N : v;
  endfunction

  always_comb begin
    rot_w = '0;
    src_w = '0;
    for (int i = 0; i < N; i++) begin
      src_w    = IDW'(wrap(int'(ptr_i) + i));
      rot_w[i] = req_i[src_w];
    end
  end

  assign any_o = |rot_w;

  // Descending scan so the lowest rotated position wins.
  always_comb begin
    off_w = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot_w[i]) off_w = IDW'(i);
    end
  end

  always_comb begin
    idx_o = IDW'(wrap(int'(ptr_i) + int'(off_w)));
    gnt_o = '0;
    if (any_o) gnt_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/fmult_arbiter.sv
// Round-robin arbiter sharing one fmult between NREQ requesters, with a one-entry
// registered output stage. FMULT_ARB_STICKY_OVR_EN enables per-requester sticky overflow.
module fmult_arbiter
  import fmult_arb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int FRAC  = FRAC_DEF,
  parameter int NREQ  = NREQ_DEF,
  localparam int ID_W = id_w(NREQ)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NREQ-1:0]       i_req,
  input  logic [NREQ*WIDTH-1:0] i_a,
  input  logic [NREQ*WIDTH-1:0] i_b,
  output logic [NREQ-1:0]       o_gnt,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [WIDTH-1:0]      o_result,
  output logic                  o_ovr,
  output logic [ID_W-1:0]       o_id,
  input  logic [NREQ-1:0]       i_ovr_clr,
  output logic [NREQ-1:0]       o_ovr_sticky
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             ovr;
    logic [ID_W-1:0]  id;
  } res_t;

  res_t            res_q, res_d;
  logic            valid_q, valid_d;
  logic [ID_W-1:0] ptr_q, ptr_d;

  logic [NREQ-1:0]  pick_gnt_w;
  logic [ID_W-1:0]  pick_idx_w;
  logic             pick_any_w;
  logic             can_issue_w;
  logic             grant_w;
  logic [WIDTH-1:0] a_sel_w;
  logic [WIDTH-1:0] b_sel_w;
  logic [WIDTH-1:0] prod_w;
  logic             prod_ovr_w;

  fmult_rr_pick #(
    .N   (NREQ),
    .IDW (ID_W)
  ) u_pick (
    .req_i (i_req),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt_w),
    .idx_o (pick_idx_w),
    .any_o (pick_any_w)
  );

  // Handshake: the result moves to the consumer on a cycle where o_valid && i_ready;
  // a new grant is allowed only when the output slot is empty or being drained.
  assign can_issue_w = !valid_q || i_ready;
  assign grant_w     = can_issue_w && pick_any_w && !i_rst;
  assign o_gnt       = grant_w ? pick_gnt_w : '0;

  assign a_sel_w = i_a[int'(pick_idx_w)*WIDTH +: WIDTH];
  assign b_sel_w = i_b[int'(pick_idx_w)*WIDTH +: WIDTH];

  fmult #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_fmult (
    .i_a   (a_sel_w),
    .i_b   (b_sel_w),
    .i_ovr (1'b0),
    .o_p   (prod_w),
    .o_ovr (prod_ovr_w)
  );

  always_comb begin
    res_d   = res_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (grant_w) begin
      res_d.result = prod_w;
      res_d.ovr    = prod_ovr_w;
      res_d.id     = pick_idx_w;
      valid_d      = 1'b1;
      ptr_d        = (int'(pick_idx_w) == NREQ - 1) ? '0 : pick_idx_w + 1'b1;
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      res_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      res_q   <= res_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign o_valid  = valid_q;
  assign o_result = res_q.result;
  assign o_ovr    = res_q.ovr;
  assign o_id     = res_q.id;

`ifdef FMULT_ARB_STICKY_OVR_EN
  logic [NREQ-1:0] sticky_q, sticky_d;
  logic [NREQ-1:0] sticky_set_w;

  // Set is applied after the clear so a simultaneous set wins.
  always_comb begin
    sticky_set_w = '0;
    if (valid_q && i_ready && res_q.ovr) sticky_set_w[res_q.id] = 1'b1;
    sticky_d = (sticky_q & ~i_ovr_clr) | sticky_set_w;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) sticky_q <= '0;
    else       sticky_q <= sticky_d;
  end

  assign o_ovr_sticky = sticky_q;
`else
  logic unused_ovr_clr;
  assign unused_ovr_clr = ^i_ovr_clr;
  assign o_ovr_sticky   = '0;
`endif

endmodule

// File: tb/tb_fmult_arbiter.sv
// Bench for fmult_arbiter: directed scenarios plus a random soak, checked by a
// grant model and a result scoreboard.
module tb_fmult_arbiter;

  localparam int WIDTH = 16;
  localparam int FRAC  = 7;
  localparam int NREQ  = 4;
  localparam int ID_W  = 2;
`ifdef FMULT_ARB_STICKY_OVR_EN
  localparam bit STICKY_EN = 1'b1;
`else
  localparam bit STICKY_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  tb_rst;
  logic [NREQ-1:0]       tb_req;
  logic [NREQ*WIDTH-1:0] tb_a, tb_b;
  logic                  tb_ready;
  logic [NREQ-1:0]       tb_clr;
  logic [NREQ-1:0]       o_gnt;
  logic                  o_valid;
  logic [WIDTH-1:0]      o_result;
  logic                  o_ovr;
  logic [ID_W-1:0]       o_id;
  logic [NREQ-1:0]       o_ovr_sticky;

  fmult_arbiter #(.WIDTH(WIDTH), .FRAC(FRAC), .NREQ(NREQ)) dut (
    .i_clk        (clk),
    .i_rst        (tb_rst),
    .i_req        (tb_req),
    .i_a          (tb_a),
    .i_b          (tb_b),
    .o_gnt        (o_gnt),
    .o_valid      (o_valid),
    .i_ready      (tb_ready),
    .o_result     (o_result),
    .o_ovr        (o_ovr),
    .o_id         (o_id),
    .i_ovr_clr    (tb_clr),
    .o_ovr_sticky (o_ovr_sticky)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference multiply: {ovr, id, result}
  function automatic logic [18:0] fm_model(input logic [15:0] a, input logic [15:0] b, input int id);
    longint p, s;
    logic ov;
    p  = longint'($signed(a)) * longint'($signed(b));
    s  = p >>> FRAC;
    ov = (s > 32767) || (s < -32768);
    return {ov, 2'(id), s[15:0]};
  endfunction

  // ---------------- scoreboard ----------------
  logic [18:0]     exp_q[$];
  logic [18:0]     mon_e;
  logic [NREQ-1:0] m_sticky = '0;

  // Grant / valid model
  int              m_ptr = 0;
  bit              m_valid = 1'b0;
  logic [NREQ-1:0] last_gnt = '0;
  int              wait_cnt[NREQ];

  always @(negedge clk) begin : grant_model
    logic [NREQ-1:0] eg;
    bit can, found;
    int k;
    eg = '0;
    found = 1'b0;
    k = 0;
    if (tb_rst) begin
      check("gnt_in_reset", o_gnt, 0);
      m_ptr = 0;
      m_valid = 1'b0;
      last_gnt = '0;
      for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
    end else begin
      check("valid", o_valid, m_valid);
      can = !m_valid || tb_ready;
      for (int i = 0; i < NREQ; i++) begin
        if (!found && can && tb_req[(m_ptr + i) % NREQ]) begin
          found = 1'b1;
          k = (m_ptr + i) % NREQ;
        end
      end
      if (found) eg[k] = 1'b1;
      check("gnt", o_gnt, eg);
      last_gnt = eg;
      if (found) begin
        exp_q.push_back(fm_model(tb_a[k*WIDTH +: WIDTH], tb_b[k*WIDTH +: WIDTH], k));
        check("wait_bound", 32'(wait_cnt[k] < NREQ), 1);
        for (int i = 0; i < NREQ; i++) begin
          if (i == k || !tb_req[i]) wait_cnt[i] = 0;
          else wait_cnt[i]++;
        end
        m_ptr = (k + 1) % NREQ;
        m_valid = 1'b1;
      end else if (m_valid && tb_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin : monitor
    logic [NREQ-1:0] set_v;
    set_v = '0;
    if (tb_rst) begin
      exp_q.delete();
      m_sticky = '0;
    end else begin
      check("sticky", o_ovr_sticky, m_sticky);
      if (o_valid && tb_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'(o_valid), 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("result", o_result, mon_e[15:0]);
          check("ovr", o_ovr, mon_e[18]);
          check("id", o_id, mon_e[17:16]);
          if (mon_e[18]) set_v[mon_e[17:16]] = 1'b1;
        end
      end
      if (STICKY_EN) m_sticky = (m_sticky & ~tb_clr) | set_v;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    tb_rst = 1'b1;
    tb_req = '0;
    step();
    tb_rst = 1'b0;
  endtask

  task automatic set_ops(input int k, input logic [15:0] a, input logic [15:0] b);
    tb_a[k*WIDTH +: WIDTH] = a;
    tb_b[k*WIDTH +: WIDTH] = b;
  endtask

  task automatic rand_step(input bit allow_new);
    logic [15:0] va, vb;
    step();
    for (int k = 0; k < NREQ; k++) begin
      if (tb_req[k] && last_gnt[k]) tb_req[k] = 1'b0;
      if (!tb_req[k] && allow_new && $urandom_range(0, 2) == 0) begin
        va = 16'($urandom_range(0, 65535));
        vb = 16'($urandom_range(0, 65535));
        if ($urandom_range(0, 1) == 1) begin
          va = 16'($urandom_range(0, 2047)) - 16'd1024;
          vb = 16'($urandom_range(0, 2047)) - 16'd1024;
        end
        set_ops(k, va, vb);
        tb_req[k] = 1'b1;
      end
    end
    tb_ready = ($urandom_range(0, 3) != 0);
  endtask

  int exp_order[6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    tb_rst = 1'b1;
    tb_req = '0;
    tb_a = '0;
    tb_b = '0;
    tb_ready = 1'b1;
    tb_clr = '0;
    repeat (3) @(posedge clk);
    #1 tb_rst = 1'b0;

    // reset state
    @(negedge clk);
    check("rst_valid", o_valid, 0);
    check("rst_result", o_result, 0);
    check("rst_ovr", o_ovr, 0);
    check("rst_id", o_id, 0);
    check("rst_sticky", o_ovr_sticky, 0);
    check("rst_gnt", o_gnt, 0);

    // single requester 2: 2.0 * 3.0
    step();
    set_ops(2, 16'd256, 16'd384);
    tb_req = 4'b0100;
    @(negedge clk);
    check("t1_gnt", o_gnt, 4'b0100);
    step();
    tb_req = '0;
    @(negedge clk);
    check("t1_valid", o_valid, 1);
    check("t1_result", o_result, 768);
    check("t1_ovr", o_ovr, 0);
    check("t1_id", o_id, 2);

    // all requesting, full throughput rotation
    do_reset();
    for (int k = 0; k < NREQ; k++) set_ops(k, 16'((k + 1) * 128), 16'd384);
    tb_req = '1;
    tb_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t2_order", o_gnt, 32'(1) << exp_order[i]);
      step();
    end

    // backpressure with requests pending
    tb_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_gnt", o_gnt, 0);
      check("t3_valid", o_valid, 1);
      check("t3_id", o_id, 1);
      check("t3_result", o_result, 768);
      step();
    end
    tb_ready = 1'b1;
    @(negedge clk);
    check("t3_resume_gnt", o_gnt, 4'b0100);
    step();
    tb_req = '0;
    @(negedge clk);
    check("t3_resume_id", o_id, 2);
    check("t3_resume_result", o_result, 1152);

    // overflow and sticky flag on requester 1
    do_reset();
    set_ops(1, 16'h4000, 16'h4000);
    tb_req = 4'b0010;
    @(negedge clk);
    check("t4_gnt", o_gnt, 4'b0010);
    step();
    tb_req = '0;
    @(negedge clk);
    check("t4_ovr", o_ovr, 1);
    check("t4_result", o_result, 0);
    check("t4_id", o_id, 1);
    step();
    @(negedge clk);
    check("t4_sticky_set", o_ovr_sticky, STICKY_EN ? 4'b0010 : 4'b0000);
    step();
    tb_clr = 4'b0010;
    step();
    tb_clr = '0;
    @(negedge clk);
    check("t4_sticky_clr", o_ovr_sticky, 0);

    // reset while holding a result with ptr at 3
    do_reset();
    set_ops(2, 16'd256, 16'd256);
    tb_req = 4'b0100;
    tb_ready = 1'b0;
    @(negedge clk);
    check("t5_gnt", o_gnt, 4'b0100);
    step();
    tb_req = '0;
    @(negedge clk);
    check("t5_held", o_valid, 1);
    step();
    tb_rst = 1'b1;
    step();
    tb_rst = 1'b0;
    tb_ready = 1'b1;
    set_ops(1, 16'd128, 16'd128);
    set_ops(3, 16'd640, 16'hff80);
    tb_req = 4'b1010;
    @(negedge clk);
    check("t5_valid_cleared", o_valid, 0);
    check("t5_first_gnt", o_gnt, 4'b0010);
    step();
    tb_req = 4'b1000;
    @(negedge clk);
    check("t5_second_gnt", o_gnt, 4'b1000);
    check("t5_result", o_result, 128);
    step();
    tb_req = '0;
    @(negedge clk);
    check("t5_neg_result", o_result, 16'hfd80);

    // random soak
    for (int c = 0; c < 10000; c++) rand_step(1'b1);
    for (int c = 0; c < 200 && tb_req != '0; c++) rand_step(1'b0);
    check("drain_req", tb_req, 0);
    tb_ready = 1'b1;
    repeat (3) step();
    check("drain_queue", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    n_errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fmult_arbiter.md
# fmult_arbiter

Round-robin arbiter that shares one `fmult` fixed-point multiplier between `NREQ` requesters inside the adaptive filter, such as FIR tap products and LMS coefficient updates. Each cycle it grants at most one pending requester and drives that requester's operands into the multiplier. It registers the product together with the overflow flag and the requester ID. A one-entry output stage with valid/ready backpressure stalls all grants while the consumer is not ready.

## Interface
- `WIDTH`, 16, operand/result width (two's complement)
- `FRAC`, 7, fractional bits; passed unchanged to `fmult`
- `NREQ`, 4, number of requesters (2..16)
- `i_clk`  in  1  clock; all state updates on the rising edge
- `i_rst`  in  1  synchronous, active-high reset
- `i_req`  in  NREQ  per-requester request; held high with stable operands until granted
- `i_a`  in  NREQ×WIDTH  multiplicand per requester
- `i_b`  in  NREQ×WIDTH  multiplier per requester
- `o_gnt`  out  NREQ  one-hot grant, combinational, same cycle as the accept
- `o_valid`  out  1  result register holds a valid product
- `i_ready`  in  1  consumer accepts the result when `o_valid && i_ready`
- `o_result`  out  WIDTH  registered product
- `o_ovr`  out  1  registered `fmult` overflow for `o_result`
- `o_id`  out  $clog2(NREQ)  index of the requester that owns `o_result`
- `i_ovr_clr`  in  NREQ  clears sticky overflow per requester (see Configuration)
- `o_ovr_sticky`  out  NREQ  sticky overflow per requester (see Configuration)

## Operation
- `can_issue = !o_valid || i_ready`. No grant is issued when `can_issue` is low.
- Round-robin pointer `ptr`: the grant goes to the first `i_req[k]` set, searching k = ptr, ptr+1, … modulo NREQ. The search wraps from NREQ-1 to 0.
- On a grant to k:
  - `ptr <= (k+1) mod NREQ`.
  - `i_a[k]`/`i_b[k]` are muxed into `fmult` with `i_ovr = 0`.
  - `o_result`, `o_ovr` and `o_id <= k` load; `o_valid <= 1`.
- No grant and `o_valid && i_ready`: `o_valid <= 0`. `ptr` is unchanged.
- Accept and new grant in the same cycle: the register reloads and `o_valid` stays 1. This gives full throughput of one product per cycle.
- No requests: `o_gnt = 0` and `ptr` holds.
- `o_gnt` depends only on `i_req`, `ptr`, `o_valid` and `i_ready`. It never depends on operands.
- A requester that drops `i_req` before being granted is not an error; the request is simply withdrawn.
- Arithmetic: `o_result`/`o_ovr` equal bit-exactly what `fmult #(WIDTH,FRAC)` produces for the granted operands.

## Timing
- Reset values: `o_valid=0`, `o_result=0`, `o_ovr=0`, `o_id=0`, `ptr=0`, `o_ovr_sticky=0`. `o_gnt=0` while `i_rst` is high.
- Latency is 1 cycle: a grant in cycle n gives `o_valid` and data in cycle n+1.
- Reset mid-operation discards any held result and returns the pointer to 0. It takes priority over every other update in the same cycle.
- Fairness: with all requests high and `i_ready=1`, grants rotate 0,1,…,NREQ-1,0. No requester waits more than NREQ grant cycles.
- Output is stable while `o_valid && !i_ready`.

## Configuration
- `FMULT_ARB_STICKY_OVR_EN` defined:
  - `o_ovr_sticky[k]` sets when a result with `o_ovr=1` and `o_id=k` is accepted (`o_valid && i_ready`).
  - `i_ovr_clr[k]` clears it; set wins over a simultaneous clear.
- Not defined: `o_ovr_sticky` is tied to 0 and `i_ovr_clr` is ignored. Ports remain present.

## Structure
- `fmult_arb_pkg`: `NREQ` default, an `ID_W` constant/function (`$clog2`), and a typedef for the result record (`result`, `ovr`, `id`).
- Sub-module `fmult_rr_pick`: a combinational rotate, priority-select and unrotate block. It takes `req` and `ptr` and returns a one-hot grant plus an index.
- The existing `fmult` is instantiated once, unmodified.

## Test plan
- Single requester 2, `i_a=256` (2.0), `i_b=384` (3.0), `i_ready=1` → `o_gnt=0100`; next cycle `o_valid=1`, `o_result=768`, `o_ovr=0`, `o_id=2`.
- All four requesting continuously, `i_ready=1` → grant order 0,1,2,3,0,1 on consecutive cycles, with no idle cycles.
- Result held, `i_ready=0` for 3 cycles with requests pending → `o_gnt=0`, output stable; a grant occurs in the same cycle `i_ready` rises.
- `i_a=0x4000`, `i_b=0x4000` on requester 1 → `o_ovr` matches `fmult`. With the macro, `o_ovr_sticky=0010` after accept; pulsing `i_ovr_clr[1]` clears it. Without the macro it stays 0.
- Reset asserted while `o_valid=1` and `ptr=3` → next cycle `o_valid=0` and `ptr=0`; the first grant after reset goes to the lowest requesting index.
- Random requests/operands/`i_ready` over 10k cycles → every product matches a model of `fmult`, no requests are lost, and every wait is ≤ NREQ grants.
